dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-port 8-bit data memory. Port A is the pipeline MEM stage. Port B is the debug/loader (DMA) port. The block picks one command per cycle, registers it onto the memory command bus, and routes the one-cycle-late registered read data back to the issuing port. Port A has fixed priority, and a starvation counter bounds how long port B can wait.

Parameters:
STARVE_LIMIT, 4, consecutive losing cycles of B after which B wins the next contended cycle; 0 = pure fixed priority (B never forced)
CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_a  in  1  port A request; held with we_a/addr_a/wdata_a stable until gnt_a
we_a  in  1  1 = write, 0 = read
addr_a  in  8  port A address
wdata_a  in  8  port A write data
gnt_a  out  1  combinational; command accepted this cycle
rvalid_a  out  1  read data for port A valid this cycle
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b  as port A, for port B
rdata  out  8  shared read data (= mem_rdata); qualify with rvalid_a/rvalid_b
mem_read  out  1  registered; to memory memread
mem_write  out  1  registered; to memory memwrite
mem_addr  out  8  registered; to memory addr
mem_wdata  out  8  registered; to memory writedata
mem_rdata  in  8  from memory readdata (registered inside the memory)
conflict_cnt  out  16  contention statistic (see Optional Feature)

Behaviour:
- Reset (synchronous, while reset=1):
  - mem_read, mem_write, rvalid_a, rvalid_b = 0; mem_addr, mem_wdata = 0x00.
  - Starvation counter = 0; read-tag pipeline cleared.
  - gnt_a and gnt_b are forced to 0.
  - A read in flight when reset asserts produces no rvalid.
- Arbitration (combinational, each cycle):
  - Only A requests: gnt_a = 1.
  - Only B requests: gnt_b = 1.
  - Both request: gnt_b = 1 if STARVE_LIMIT != 0 and wait_cnt == STARVE_LIMIT; otherwise gnt_a = 1.
  - gnt_a and gnt_b are never high together. No request: both 0.
- Starvation counter wait_cnt:
  - Increments, saturating at STARVE_LIMIT, in any cycle where req_b=1 and gnt_b=0.
  - Clears to 0 on gnt_b or when req_b=0.
- Issue pipeline, for a grant in cycle N:
  - In cycle N+1, mem_addr/mem_wdata hold the winner's fields; mem_write = we, mem_read = ~we.
  - In cycle N+1 with no grant in N: mem_read = mem_write = 0; addr/wdata hold their last values.
- Read return:
  - A 1-cycle tag register records {read, port} at issue.
  - The memory registers readdata at the end of N+1, so rvalid_x = 1 in cycle N+2 with rdata = mem_rdata.
  - Writes produce no rvalid.
  - Total read latency is 2 cycles from grant; no acknowledgement handshake on the return path.
- Throughput and ordering:
  - One command per cycle, back-to-back grants allowed to the same or alternating ports.
  - Commands reach memory in grant order.
  - A write granted in N followed by a read of the same address granted in N+1 returns the new data.
- A requester may change its fields or drop req the cycle after gnt. A requester that drops req before gnt cancels the request cleanly.

Optional Feature:
Macro: DMEM_ARB_STATS_EN.
- Defined: conflict_cnt increments in every cycle with req_a=1 and req_b=1 (reset=0). It saturates at 0xFFFF and is cleared by reset.
- Undefined: no counter logic; conflict_cnt tied to 0x0000.
- Arbitration is identical in both builds.

Test Plan:
1. Reset held 3 cycles with req_a=1 → gnt_a=0, mem_read=mem_write=0, rvalid_a=rvalid_b=0, mem_addr=0x00 throughout. Release reset → gnt_a=1 in the first cycle after.
2. A write addr=0x10 data=0x5A in cycle N → mem_write=1, mem_addr=0x10, mem_wdata=0x5A in N+1. A read 0x10 granted N+1 → rvalid_a=1, rdata=0x5A in N+3.
3. Simultaneous single-cycle requests, A read 0x20, B read 0x21 (memory preloaded 0x11/0x22):
   - cycle N: gnt_a only; cycle N+1: gnt_b.
   - rvalid_a with rdata=0x11 in N+2; rvalid_b with rdata=0x22 in N+3.
4. STARVE_LIMIT=4, req_a held high every cycle, req_b raised at cycle 0 → gnt_a in cycles 0–3, gnt_b in cycle 4, gnt_a in cycle 5, wait_cnt=0 after cycle 4.
5. A read granted in cycle N, reset asserted in N+1 → no rvalid_a in N+2; all outputs at reset values.
6. DMEM_ARB_STATS_EN defined, both ports requesting for 10 cycles → conflict_cnt=10. Macro undefined, same stimulus → conflict_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-port 8-bit data memory.
// Port A (pipeline MEM stage) has fixed priority; port B (debug/loader) is protected from
// starvation by a wait counter. Commands are registered onto the memory bus one cycle after
// grant, and read data is routed back to the issuing port two cycles after grant.
// Optional build macro DMEM_ARB_STATS_EN enables the conflict_cnt contention statistic.

module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  // Port A: pipeline MEM stage
  input  logic        req_a,
  input  logic        we_a,
  input  logic [7:0]  addr_a,
  input  logic [7:0]  wdata_a,
  output logic        gnt_a,
  output logic        rvalid_a,
  // Port B: debug / loader
  input  logic        req_b,
  input  logic        we_b,
  input  logic [7:0]  addr_b,
  input  logic [7:0]  wdata_b,
  output logic        gnt_b,
  output logic        rvalid_b,
  // Shared read data
  output logic [7:0]  rdata,
  // Memory command bus
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  // Statistics
  output logic [15:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] Limit   = CNT_W'(STARVE_LIMIT);
  localparam bit               ForceEn = (STARVE_LIMIT != 0);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [7:0]       mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  // Port that issued the command now on the bus (0 = A, 1 = B); with mem_read_q it forms
  // the read tag.
  logic             tag_port_q, tag_port_d;
  logic             rvalid_a_q, rvalid_a_d;
  logic             rvalid_b_q, rvalid_b_d;
  logic             force_b;
  logic             gnt_a_c, gnt_b_c;

  // Arbitration: A wins contention unless B has waited STARVE_LIMIT cycles.
  always_comb begin
    force_b = ForceEn && (wait_cnt_q == Limit);
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (!reset) begin
      if (req_a && req_b) begin
        if (force_b) begin
          gnt_b_c = 1'b1;
        end else begin
          gnt_a_c = 1'b1;
        end
      end else if (req_a) begin
        gnt_a_c = 1'b1;
      end else if (req_b) begin
        gnt_b_c = 1'b1;
      end
    end
  end

  assign gnt_a = gnt_a_c;
  assign gnt_b = gnt_b_c;

  // Starvation counter: counts B's losing cycles, saturating at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (reset || !req_b || gnt_b_c) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != Limit) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Issue stage and read-return tag: next-state of the memory command bus.
  always_comb begin
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag_port_d  = tag_port_q;
    // Read data arrives the cycle after the read sits on the bus.
    rvalid_a_d  = mem_read_q && !tag_port_q;
    rvalid_b_d  = mem_read_q && tag_port_q;
    if (gnt_a_c) begin
      mem_read_d  = !we_a;
      mem_write_d = we_a;
      mem_addr_d  = addr_a;
      mem_wdata_d = wdata_a;
      tag_port_d  = 1'b0;
    end else if (gnt_b_c) begin
      mem_read_d  = !we_b;
      mem_write_d = we_b;
      mem_addr_d  = addr_b;
      mem_wdata_d = wdata_b;
      tag_port_d  = 1'b1;
    end
    if (reset) begin
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = 8'h00;
      mem_wdata_d = 8'h00;
      tag_port_d  = 1'b0;
      rvalid_a_d  = 1'b0;
      rvalid_b_d  = 1'b0;
    end
  end

  // State registers (reset folded into the next-state logic above).
  always_ff @(posedge clk) begin
    wait_cnt_q  <= wait_cnt_d;
    mem_read_q  <= mem_read_d;
    mem_write_q <= mem_write_d;
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
    tag_port_q  <= tag_port_d;
    rvalid_a_q  <= rvalid_a_d;
    rvalid_b_q  <= rvalid_b_d;
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = mem_rdata;
  // Gating with reset kills a return that would land in the first reset cycle.
  assign rvalid_a  = rvalid_a_q && !reset;
  assign rvalid_b  = rvalid_b_q && !reset;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  // Contention statistic: cycles with both ports requesting, saturating.
  always_comb begin
    conflict_d = conflict_q;
    if (reset) begin
      conflict_d = 16'h0000;
    end else if (req_a && req_b && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'h0001;
    end
  end

  // Statistic register.
  always_ff @(posedge clk) begin
    conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a registered-read memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, we_a = 1'b0;
  logic [7:0]  addr_a = 8'h00, wdata_a = 8'h00;
  logic        req_b = 1'b0, we_b = 1'b0;
  logic [7:0]  addr_b = 8'h00, wdata_b = 8'h00;
  logic        gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [7:0]  rdata;
  logic        mem_read, mem_write;
  logic [7:0]  mem_addr, mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] conflict_cnt;

  logic [7:0]  mem [256];

  int checks = 0;
  int failures = 0;

`ifdef DMEM_ARB_STATS_EN
  localparam logic [15:0] ExpConflict = 16'd10;
`else
  localparam logic [15:0] ExpConflict = 16'd0;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(
    .STARVE_LIMIT(4),
    .CNT_W       (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_a       (req_a),
    .we_a        (we_a),
    .addr_a      (addr_a),
    .wdata_a     (wdata_a),
    .gnt_a       (gnt_a),
    .rvalid_a    (rvalid_a),
    .req_b       (req_b),
    .we_b        (we_b),
    .addr_b      (addr_b),
    .wdata_b     (wdata_b),
    .gnt_b       (gnt_b),
    .rvalid_b    (rvalid_b),
    .rdata       (rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Single-port memory with registered read data.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = 1'b0;
    req_b = 1'b0;
    we_a  = 1'b0;
    we_b  = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    req_a  = 1'b1;
    we_a   = 1'b0;
    addr_a = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (gnt_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_gnt_a cyc=%0d got=%b exp=0", i, gnt_a);
      end
      checks++;
      if ({mem_read, mem_write, rvalid_a, rvalid_b} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_ctrl cyc=%0d got=%b exp=0000", i,
                 {mem_read, mem_write, rvalid_a, rvalid_b});
      end
      checks++;
      if (mem_addr !== 8'h00) begin
        failures++;
        $display("FAIL reset_addr cyc=%0d got=%h exp=00", i, mem_addr);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (gnt_a !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_gnt_a got=%b exp=1", gnt_a);
    end
    step();
    idle();
    step();
    step();
  endtask

  task automatic test_write_read();
    req_a   = 1'b1;
    we_a    = 1'b1;
    addr_a  = 8'h10;
    wdata_a = 8'h5A;
    #1;
    checks++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      failures++;
      $display("FAIL wr_gnt got=%b exp=10", {gnt_a, gnt_b});
    end
    step();
    checks++;
    if ({mem_write, mem_read, mem_addr, mem_wdata} !== {2'b10, 8'h10, 8'h5A}) begin
      failures++;
      $display("FAIL wr_issue got w=%b r=%b a=%h d=%h exp w=1 r=0 a=10 d=5a",
               mem_write, mem_read, mem_addr, mem_wdata);
    end
    we_a = 1'b0;
    #1;
    checks++;
    if (gnt_a !== 1'b1) begin
      failures++;
      $display("FAIL rd_gnt got=%b exp=1", gnt_a);
    end
    step();
    idle();
    checks++;
    if ({mem_read, mem_write, mem_addr} !== {2'b10, 8'h10}) begin
      failures++;
      $display("FAIL rd_issue got r=%b w=%b a=%h exp r=1 w=0 a=10",
               mem_read, mem_write, mem_addr);
    end
    step();
    checks++;
    if ({rvalid_a, rvalid_b, rdata} !== {2'b10, 8'h5A}) begin
      failures++;
      $display("FAIL raw_return got va=%b vb=%b d=%h exp va=1 vb=0 d=5a",
               rvalid_a, rvalid_b, rdata);
    end
    checks++;
    if ({mem_read, mem_write, mem_addr} !== {2'b00, 8'h10}) begin
      failures++;
      $display("FAIL idle_hold got r=%b w=%b a=%h exp r=0 w=0 a=10",
               mem_read, mem_write, mem_addr);
    end
    step();
  endtask

  task automatic test_contention();
    mem[8'h20] = 8'h11;
    mem[8'h21] = 8'h22;
    req_a  = 1'b1;
    we_a   = 1'b0;
    addr_a = 8'h20;
    req_b  = 1'b1;
    we_b   = 1'b0;
    addr_b = 8'h21;
    #1;
    checks++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      failures++;
      $display("FAIL cont_n got=%b exp=10", {gnt_a, gnt_b});
    end
    step();
    req_a = 1'b0;
    #1;
    checks++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      failures++;
      $display("FAIL cont_n1 got=%b exp=01", {gnt_a, gnt_b});
    end
    step();
    req_b = 1'b0;
    checks++;
    if ({rvalid_a, rvalid_b, rdata} !== {2'b10, 8'h11}) begin
      failures++;
      $display("FAIL cont_ret_a got va=%b vb=%b d=%h exp va=1 vb=0 d=11",
               rvalid_a, rvalid_b, rdata);
    end
    step();
    checks++;
    if ({rvalid_a, rvalid_b, rdata} !== {2'b01, 8'h22}) begin
      failures++;
      $display("FAIL cont_ret_b got va=%b vb=%b d=%h exp va=0 vb=1 d=22",
               rvalid_a, rvalid_b, rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    logic [1:0] exp;
    req_a  = 1'b1;
    we_a   = 1'b0;
    addr_a = 8'h00;
    req_b  = 1'b1;
    we_b   = 1'b0;
    addr_b = 8'h01;
    // B forced in cycle 4, then must wait a full 4 more losing cycles (wins again at 9).
    for (int i = 0; i < 10; i++) begin
      #1;
      exp = (i == 4 || i == 9) ? 2'b01 : 2'b10;
      checks++;
      if ({gnt_a, gnt_b} !== exp) begin
        failures++;
        $display("FAIL starve cyc=%0d got=%b exp=%b", i, {gnt_a, gnt_b}, exp);
      end
      step();
    end
    idle();
    step();
    step();
  endtask

  task automatic test_reset_in_flight();
    req_a  = 1'b1;
    we_a   = 1'b0;
    addr_a = 8'h10;
    #1;
    checks++;
    if (gnt_a !== 1'b1) begin
      failures++;
      $display("FAIL rif_gnt got=%b exp=1", gnt_a);
    end
    step();
    idle();
    reset = 1'b1;
    step();
    checks++;
    if ({rvalid_a, rvalid_b, mem_read, mem_write, gnt_a, gnt_b} !== 6'b000000) begin
      failures++;
      $display("FAIL rif_ctrl got va=%b vb=%b r=%b w=%b ga=%b gb=%b exp all 0",
               rvalid_a, rvalid_b, mem_read, mem_write, gnt_a, gnt_b);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 16'h0000) begin
      failures++;
      $display("FAIL rif_bus got a=%h d=%h exp a=00 d=00", mem_addr, mem_wdata);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_stats();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (conflict_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL stats_reset got=%h exp=0000", conflict_cnt);
    end
    req_a  = 1'b1;
    addr_a = 8'h40;
    req_b  = 1'b1;
    addr_b = 8'h41;
    for (int i = 0; i < 10; i++) step();
    idle();
    #1;
    checks++;
    if (conflict_cnt !== ExpConflict) begin
      failures++;
      $display("FAIL stats_count got=%0d exp=%0d", conflict_cnt, ExpConflict);
    end
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_write_read();
    test_contention();
    test_starvation();
    test_reset_in_flight();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
